bit_stream_deserializer: RTL
============================

Name: bit_stream_deserializer

Overview:
- Upstream feeder for the combinational pattern-detector stage.
- Collects a serial bit stream (valid/ready handshake) into WIDTH-bit words and presents each completed word on a registered output with a valid/ready handshake.
- The word output drives the detector's 32-bit data input directly.
- Includes a one-word output holding register, so bit intake continues while the consumer stalls.

Parameters:
- WIDTH, 32, bits per assembled word; legal range 4..64.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts bit_in this cycle.
- flush  input  1  synchronous; discards the partial word.
- word_out  output  WIDTH  assembled word (registered).
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out this cycle.
- word_count  output  CNT_W  number of words handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): shift register=0, bit_cnt=0, word_out=0, word_valid=0, word_count=0. bit_ready is combinational: 1 after reset.
- Accept condition: a bit is accepted when bit_valid && bit_ready.
- Bit order (default LSB-first): the k-th accepted bit of a word (k=0..WIDTH-1) lands in bit k. The first received bit therefore becomes word_out[0].
- bit_cnt: 0..WIDTH.
  - Increments on each accepted bit.
  - bit_cnt==WIDTH means a complete word is parked in the shift register.
- out_free = !word_valid || word_ready.
- Transfer: occurs when a complete word is available and out_free.
  - "Complete word available" means bit_cnt==WIDTH, or bit_cnt==WIDTH-1 with a bit accepted this cycle.
  - On transfer: word_out is loaded, word_valid=1 next cycle, word_count+1.
- Latency: last bit accepted in cycle N with out_free gives word_valid=1 in cycle N+1 (1-cycle latency, no bubble).
- bit_ready = (bit_cnt != WIDTH) || out_free.
  - Full throughput: 1 bit/cycle sustained while the consumer keeps up.
- Simultaneous events:
  - bit_cnt==WIDTH with out_free and a bit accepted: the parked word transfers and the new bit becomes bit 0 of the next word (bit_cnt=1).
  - word_ready with no transfer: word_valid drops to 0 next cycle.
  - word_ready with a transfer: word_valid stays 1 and word_out updates.
- Backpressure:
  - word_valid=1, !word_ready, bit_cnt==WIDTH: bit_ready=0; all state holds.
  - word_out must remain stable while word_valid && !word_ready.
- flush:
  - Sets bit_cnt=0 and clears the shift register; bits presented that cycle are dropped.
  - Does not affect word_out, word_valid or word_count. A parked complete word (bit_cnt==WIDTH) is also discarded.
  - flush has priority over accept and transfer from the shift register.
- Reset mid-word or mid-handshake: everything is cleared immediately; the pending word is lost.
- word_count wraps from 2^CNT_W-1 to 0 silently.

Optional Feature:
- Macro: DESER_MSB_FIRST_EN.
  - Defined: first accepted bit of a word lands in bit WIDTH-1, last in bit 0. The shift register shifts left, inserting at the LSB.
  - Undefined: LSB-first order as described in Behaviour.
- Handshake, latency and counters are identical in both builds.

Decomposition:
- Shared package deser_pkg:
  - Default WIDTH/CNT_W constants.
  - Bit-counter width function clog2(WIDTH+1).
  - Typedef for the word type, shared with the pattern-detector stage.
- No sub-module needed. Optionally split the output holding register as deser_out_reg (word_out, word_valid, out_free logic), reusable as a generic one-entry valid/ready register.

Test Plan:
- Reset then stream bits 1,0,1,0,... (32 bits, LSB-first), word_ready=1 -> word_out=32'h5555_5555 one cycle after the 32nd bit, word_count=1.
- Stream 64 continuous bits encoding 32'hDEAD_BEEF then 32'h0000_0007, word_ready=1 -> two back-to-back words, bit_ready never low, word_count=2.
- Hold word_ready=0 after the first word and keep streaming -> second word parks, bit_ready=0 after 64 bits, word_out stays 32'hDEAD_BEEF. Release word_ready -> next cycle word_out=32'h0000_0007.
- Send 10 bits, pulse flush, send 32 bits of 32'h1234_5678 -> only 32'h1234_5678 emitted, word_count=1.
- Assert rst mid-word (after 17 bits) with word_valid=1 -> all outputs 0 immediately. The next 32 bits form a clean word.
- Build with DESER_MSB_FIRST_EN, stream bits of 32'h8000_0001 MSB-first -> word_out=32'h8000_0001.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared constants and types for the bit-stream deserializer and the downstream pattern detector.
package deser_pkg;

    localparam int unsigned DESER_WIDTH = 32;
    localparam int unsigned DESER_CNT_W = 16;

    // Word type handed to the pattern-detector stage.
    typedef logic [DESER_WIDTH-1:0] deser_word_t;

    // The bit counter must represent 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Generic one-entry valid/ready output register; free means a load this cycle cannot overwrite
// an unconsumed word.
module deser_out_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             free
);

    always_comb begin
        free = !valid || ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_stream_deserializer.sv
// Serial-to-parallel deserializer with valid/ready on both sides and a one-word output register.
// Define DESER_MSB_FIRST_EN to assemble words MSB-first (default is LSB-first).
module bit_stream_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH,
    parameter int unsigned CNT_W = DESER_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned     BC_W = cnt_width(WIDTH);
    localparam logic [BC_W-1:0] FULL = BC_W'(WIDTH);
    localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_word;
    logic [BC_W-1:0]  bit_cnt;
    logic             out_free;
    logic             parked;
    logic             accept;
    logic             xfer;

    always_comb begin
        parked    = (bit_cnt == FULL);
        bit_ready = !parked || out_free;
        accept    = bit_valid && bit_ready;
`ifdef DESER_MSB_FIRST_EN
        shifted   = {shreg[WIDTH-2:0], bit_in};
`else
        shifted   = {bit_in, shreg[WIDTH-1:1]};
`endif
        // The completing bit is bypassed straight into the output register, so no bubble cycle.
        xfer      = !flush && out_free && (parked || ((bit_cnt == LAST) && accept));
        load_word = parked ? shreg : shifted;
    end

    // Stale bits left behind after a transfer are shifted out before the next word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (flush) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (parked) begin
            if (xfer) begin
                shreg   <= shifted;
                bit_cnt <= accept ? BC_W'(1) : '0;
            end
        end else if (accept) begin
            shreg   <= shifted;
            bit_cnt <= xfer ? '0 : bit_cnt + BC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (xfer) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .load_data(load_word),
        .data     (word_out),
        .valid    (word_valid),
        .ready    (word_ready),
        .free     (out_free)
    );

endmodule
